// File: rtl/rx_fifo_ctrl.sv
// Receive-side FIFO between the UART receiver and the APB register block.
// First-word-fall-through data, registered status flags and a sticky overflow bit.
module rx_fifo_ctrl #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned AFULL_LVL = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fifo_write,
  input  logic [DATA_W-1:0] rx_byte,
  input  logic              read_rx_byte,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_empty,
  output logic              rx_full,
  output logic              receive_full,
  output logic              almost_full,
  output logic [ADDR_W:0]   rx_level,
  output logic              overflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   DepthLvl = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   AfullLvl = (ADDR_W + 1)'(AFULL_LVL);
  localparam logic [ADDR_W:0]   LvlOne   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PtrOne   = ADDR_W'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   level_q, level_d;
  logic              empty_q, full_q, afull_q, overflow_q;
  logic              wr_req, rd_req, wr_ok, rd_ok;

  always_comb begin
    wr_req = ~fifo_write;
    rd_req = read_rx_byte;
    // A read in the same cycle frees the head slot, so a write at full still fits.
    wr_ok  = wr_req & (~full_q | rd_req);
    rd_ok  = rd_req & ~empty_q;
    level_d = level_q;
    if (wr_ok && !rd_ok) begin
      level_d = level_q + LvlOne;
    end else if (rd_ok && !wr_ok) begin
      level_d = level_q - LvlOne;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + PtrOne;
      level_q <= level_d;
      // Flags come from the next-state level so they line up with rx_level.
      empty_q <= (level_d == '0);
      full_q  <= (level_d == DepthLvl);
      afull_q <= (level_d >= AfullLvl);
      if (rd_req) begin
        overflow_q <= 1'b0;
      end else if (wr_req && full_q) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage carries no reset; the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= rx_byte;
  end

  assign rx_data      = empty_q ? '0 : mem_q[rd_ptr_q];
  assign rx_empty     = empty_q;
  assign rx_full      = full_q;
  assign receive_full = ~empty_q;
  assign almost_full  = afull_q;
  assign rx_level     = level_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
// Bench for rx_fifo_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rx_fifo_ctrl;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned AFULL  = 12;
  localparam int unsigned DEPTH  = 16;

  logic              clk, reset_n, fifo_write, read_rx_byte;
  logic [DATA_W-1:0] rx_byte, rx_data;
  logic              rx_empty, rx_full, receive_full, almost_full, overflow;
  logic [ADDR_W:0]   rx_level;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 0;

  // Reference model
  logic [7:0] q[$];
  bit         m_ovf;

  rx_fifo_ctrl #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .AFULL_LVL(AFULL)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fifo_write  (fifo_write),
    .rx_byte     (rx_byte),
    .read_rx_byte(read_rx_byte),
    .rx_data     (rx_data),
    .rx_empty    (rx_empty),
    .rx_full     (rx_full),
    .receive_full(receive_full),
    .almost_full (almost_full),
    .rx_level    (rx_level),
    .overflow    (overflow)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_ovf = 0;
    end else begin
      automatic bit w = !fifo_write;
      automatic bit r = read_rx_byte;
      automatic int n = q.size();
      if (r && n > 0) void'(q.pop_front());
      if (w) begin
        if (n < DEPTH || r) q.push_back(rx_byte);
        else m_ovf = 1;
      end
      if (r) m_ovf = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      automatic int n = q.size();
      chk("m_level", 32'(rx_level), 32'(n));
      chk("m_empty", 32'(rx_empty), 32'(n == 0));
      chk("m_full", 32'(rx_full), 32'(n == DEPTH));
      chk("m_rfull", 32'(receive_full), 32'(n != 0));
      chk("m_afull", 32'(almost_full), 32'(n >= AFULL));
      chk("m_ovf", 32'(overflow), 32'(m_ovf));
      chk("m_data", 32'(rx_data), (n > 0) ? 32'(q[0]) : 32'h0);
    end
  end

  // One clock with the given strobes, then back to idle 1 ns after the edge.
  task automatic cyc(input bit w, input logic [7:0] b, input bit r);
    fifo_write   = ~w;
    rx_byte      = b;
    read_rx_byte = r;
    @(posedge clk);
    #1;
    fifo_write   = 1'b1;
    read_rx_byte = 1'b0;
  endtask

  initial begin
    reset_n = 0; fifo_write = 1; read_rx_byte = 0; rx_byte = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    cmp_en = 1;
    chk("rst_empty", 32'(rx_empty), 1);
    chk("rst_level", 32'(rx_level), 0);
    chk("rst_data", 32'(rx_data), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_afull", 32'(almost_full), 0);

    // Single byte
    cyc(1, 8'hA5, 0);
    chk("one_empty", 32'(rx_empty), 0);
    chk("one_rfull", 32'(receive_full), 1);
    chk("one_level", 32'(rx_level), 1);
    chk("one_data", 32'(rx_data), 32'hA5);
    cyc(0, 0, 1);
    chk("one_empty2", 32'(rx_empty), 1);
    chk("one_level2", 32'(rx_level), 0);
    chk("one_data2", 32'(rx_data), 0);

    // Fill, almost_full edge, overflow, ordered drain
    for (int i = 0; i < 16; i++) begin
      cyc(1, 8'(i), 0);
      if (i == 10) chk("afull_11", 32'(almost_full), 0);
      if (i == 11) chk("afull_12", 32'(almost_full), 1);
    end
    chk("fill_full", 32'(rx_full), 1);
    chk("fill_level", 32'(rx_level), 16);
    cyc(1, 8'hEE, 0);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_level", 32'(rx_level), 16);
    chk("ovf_head", 32'(rx_data), 0);
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", 32'(rx_data), 32'(i));
      cyc(0, 0, 1);
      if (i == 0) begin
        chk("ovf_clr", 32'(overflow), 0);
        chk("ovf_clr_level", 32'(rx_level), 15);
      end
    end
    chk("drain_empty", 32'(rx_empty), 1);
    chk("drain_data0", 32'(rx_data), 0);

    // Simultaneous read and write at full
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0);
    cyc(1, 8'h77, 1);
    chk("sim_level", 32'(rx_level), 16);
    chk("sim_ovf", 32'(overflow), 0);
    chk("sim_data", 32'(rx_data), 1);
    for (int i = 0; i < 16; i++) begin
      chk("sim_drain", 32'(rx_data), (i == 15) ? 32'h77 : 32'(i + 1));
      cyc(0, 0, 1);
    end

    // Empty corners
    cyc(0, 0, 1);
    chk("emp_rd_level", 32'(rx_level), 0);
    chk("emp_rd_empty", 32'(rx_empty), 1);
    cyc(1, 8'h3C, 1);
    chk("emp_wr_level", 32'(rx_level), 1);
    chk("emp_wr_data", 32'(rx_data), 32'h3C);
    cyc(0, 0, 1);

    // Interleaved pairs across pointer wrap
    for (int k = 0; k < 40; k++) begin
      cyc(1, 8'(8'h40 + k), 0);
      chk("wrap_data", 32'(rx_data), 32'(8'h40 + k));
      cyc(0, 0, 1);
    end

    // Asynchronous reset mid-stream
    for (int k = 0; k < 5; k++) cyc(1, 8'(8'h90 + k), 0);
    chk("pre_rst_level", 32'(rx_level), 5);
    #2 reset_n = 0;
    #1;
    chk("arst_level", 32'(rx_level), 0);
    chk("arst_empty", 32'(rx_empty), 1);
    chk("arst_ovf", 32'(overflow), 0);
    chk("arst_data", 32'(rx_data), 0);
    @(posedge clk);
    #1 reset_n = 1;
    cyc(1, 8'h5A, 0);
    chk("post_rst_data", 32'(rx_data), 32'h5A);
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
